servo_trajectory_player: RTL and testbench

//  Parametrised N-channel successor to the 3-servo arm driver. Plays a trajectory table from an external sync ROM:
//  per step, N_CH target angles plus a dwell time counted in 20 ms PWM frames. Adds start/stop, loop mode,
//  per-frame slew limiting, angle clamping and glitch-free pulse-width updates on frame boundaries.

---
 rtl/servo_trajectory_player_pkg.sv | 22 ++
 rtl/servo_pwm_channel.sv | 79 +++++++
 rtl/servo_trajectory_player.sv | 182 ++++++++++++++++++
 tb/tb_servo_trajectory_player.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_trajectory_player_pkg.sv
// servo_trajectory_player_pkg
//   Shared definitions for the servo trajectory player: angle width and
//   mechanical limit, FSM state encodings, and the angle clamp helper.
package servo_trajectory_player_pkg;

  localparam int ANGLE_W = 8;
  localparam logic [ANGLE_W-1:0] ANGLE_MAX = 8'd180;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Table entries beyond the mechanical range are pinned to the limit.
  function automatic logic [ANGLE_W-1:0] clamp_angle(input logic [ANGLE_W-1:0] a);
    return (a > ANGLE_MAX) ? ANGLE_MAX : a;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel
//   One servo output. Holds the slewed angle, the pulse width derived from it
//   and the registered PWM bit. Angle and width only change on frame_tick, so
//   the new width takes effect from frame_cnt == 0 of the following frame.
// Ports
//   CLK, RST    clock, asynchronous active-high reset
//   frame_tick  last cycle of the current PWM frame
//   frame_cnt   free-running frame position
//   target      angle the channel moves toward
//   angle       current (slewed) angle
//   pwm         servo pulse output
module servo_pwm_channel
  import servo_trajectory_player_pkg::*;
#(
  parameter int FRAME_W    = 20,
  parameter int PULSE_MIN  = 25_000,
  parameter int PULSE_STEP = 555,
  parameter int SLEW       = 0,
  parameter int HOME_ANGLE = 90
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               frame_tick,
  input  logic [FRAME_W-1:0] frame_cnt,
  input  logic [ANGLE_W-1:0] target,
  output logic [ANGLE_W-1:0] angle,
  output logic               pwm
);

  localparam logic [ANGLE_W-1:0] SLEW_A = ANGLE_W'(SLEW);
  localparam logic [ANGLE_W-1:0] HOME_A = ANGLE_W'(HOME_ANGLE);

  function automatic logic [FRAME_W-1:0] width_of(input logic [ANGLE_W-1:0] a);
    logic [31:0] w;
    w = 32'(PULSE_MIN) + 32'(a) * 32'(PULSE_STEP);
    return w[FRAME_W-1:0];
  endfunction

  logic [ANGLE_W-1:0] angle_reg;
  logic [ANGLE_W-1:0] angle_next;
  logic [ANGLE_W-1:0] diff;
  logic [FRAME_W-1:0] width_reg;
  logic               pwm_reg;

  // Move toward the target by at most SLEW degrees; SLEW == 0 means jump.
  always_comb begin
    angle_next = angle_reg;
    diff       = '0;
    if (SLEW == 0) begin
      angle_next = target;
    end else if (target > angle_reg) begin
      diff       = target - angle_reg;
      angle_next = angle_reg + ((diff > SLEW_A) ? SLEW_A : diff);
    end else begin
      diff       = angle_reg - target;
      angle_next = angle_reg - ((diff > SLEW_A) ? SLEW_A : diff);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      angle_reg <= HOME_A;
      width_reg <= width_of(HOME_A);
      pwm_reg   <= 1'b0;
    end else begin
      if (frame_tick) begin
        angle_reg <= angle_next;
        width_reg <= width_of(angle_next);
      end
      // On the tick cycle frame_cnt is at its maximum, so the old width
      // cannot produce a stray high cycle at the frame boundary.
      pwm_reg <= (frame_cnt < width_reg);
    end
  end

  assign angle = angle_reg;
  assign pwm   = pwm_reg;

endmodule

// File: rtl/servo_trajectory_player.sv
// servo_trajectory_player
//   Plays a trajectory table from an external synchronous ROM onto N_CH
//   servos. Each step carries N_CH target angles and a dwell measured in PWM
//   frames. Supports start/stop, looping, slew limiting and angle clamping.
// Ports
//   CLK, RST    clock, asynchronous active-high reset
//   start       pulse: begin playback at address 0 (from IDLE or DONE)
//   stop        pulse: abort playback and freeze at the current angles
//   loop_en     wrap from last_addr back to 0 instead of finishing
//   last_addr   address of the final step, captured at start
//   rom_addr    registered ROM address
//   rom_data    {ch0 angle, ..., ch(N_CH-1) angle, dwell}, one cycle latency
//   PWM         servo pulses, bit i = channel i
//   busy        playback in progress
//   done        playback finished, until the next start
//   frame_tick  one-cycle pulse on the last cycle of each PWM frame
module servo_trajectory_player
  import servo_trajectory_player_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int ADDR_W       = 8,
  parameter int DWELL_W      = 8,
  parameter int FRAME_CYCLES = 1_000_000,
  parameter int PULSE_MIN    = 25_000,
  parameter int PULSE_STEP   = 555,
  parameter int SLEW         = 0,
  parameter int HOME_ANGLE   = 90
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            loop_en,
  input  logic [ADDR_W-1:0]               last_addr,
  output logic [ADDR_W-1:0]               rom_addr,
  input  logic [N_CH*ANGLE_W+DWELL_W-1:0] rom_data,
  output logic [N_CH-1:0]                 PWM,
  output logic                            busy,
  output logic                            done,
  output logic                            frame_tick
);

  localparam int FRAME_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [ANGLE_W-1:0] HOME_A = ANGLE_W'(HOME_ANGLE);

  logic [FRAME_W-1:0] frame_cnt_reg;
  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  rom_addr_reg, rom_addr_next;
  logic [ADDR_W-1:0]  last_addr_reg, last_addr_next;
  logic [DWELL_W-1:0] dwell_reg, dwell_next;
  logic [DWELL_W-1:0] dwell_cnt_reg, dwell_cnt_next;
  logic [DWELL_W-1:0] dwell_cnt_inc;
  logic [DWELL_W-1:0] rom_dwell;
  logic [ANGLE_W-1:0] target_reg  [N_CH];
  logic [ANGLE_W-1:0] target_next [N_CH];
  logic [ANGLE_W-1:0] rom_angle   [N_CH];
  logic [ANGLE_W-1:0] angle       [N_CH];
  logic               busy_w;

  // Frame counter runs in every state, including IDLE and DONE.
  assign frame_tick = (frame_cnt_reg == FRAME_W'(FRAME_CYCLES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_cnt_reg <= '0;
    end else if (frame_tick) begin
      frame_cnt_reg <= '0;
    end else begin
      frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
    end
  end

  // Channel 0 sits in the most significant byte; dwell in the low bits.
  assign rom_dwell = rom_data[DWELL_W-1:0];

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_rom_field
      assign rom_angle[gi] = rom_data[DWELL_W + (N_CH-1-gi)*ANGLE_W +: ANGLE_W];
    end
  endgenerate

  assign busy_w        = (state_reg == ST_FETCH) || (state_reg == ST_WAIT) || (state_reg == ST_HOLD);
  assign dwell_cnt_inc = dwell_cnt_reg + DWELL_W'(1);

  always_comb begin
    state_next     = state_reg;
    rom_addr_next  = rom_addr_reg;
    last_addr_next = last_addr_reg;
    dwell_next     = dwell_reg;
    dwell_cnt_next = dwell_cnt_reg;
    target_next    = target_reg;

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start && !stop) begin
          state_next     = ST_FETCH;
          rom_addr_next  = '0;
          last_addr_next = last_addr;
        end
      end
      ST_FETCH: state_next = ST_WAIT;   // ROM read latency
      ST_WAIT: begin
        state_next = ST_HOLD;
        for (int i = 0; i < N_CH; i++) begin
          target_next[i] = clamp_angle(rom_angle[i]);
        end
        // A zero dwell would never match the incremented counter.
        dwell_next     = (rom_dwell == '0) ? DWELL_W'(1) : rom_dwell;
        dwell_cnt_next = '0;
      end
      ST_HOLD: begin
        if (frame_tick) begin
          dwell_cnt_next = dwell_cnt_inc;
          if (dwell_cnt_inc == dwell_reg) begin
            if (rom_addr_reg != last_addr_reg) begin
              rom_addr_next = rom_addr_reg + ADDR_W'(1);
              state_next    = ST_FETCH;
            end else if (loop_en) begin
              rom_addr_next = '0;
              state_next    = ST_FETCH;
            end else begin
              state_next = ST_DONE;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Abort: park the targets on the present angles so motion freezes while
    // the PWM keeps refreshing the servos.
    if (stop && busy_w) begin
      state_next  = ST_IDLE;
      target_next = angle;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= ST_IDLE;
      rom_addr_reg  <= '0;
      last_addr_reg <= '0;
      dwell_reg     <= DWELL_W'(1);
      dwell_cnt_reg <= '0;
      for (int i = 0; i < N_CH; i++) begin
        target_reg[i] <= HOME_A;
      end
    end else begin
      state_reg     <= state_next;
      rom_addr_reg  <= rom_addr_next;
      last_addr_reg <= last_addr_next;
      dwell_reg     <= dwell_next;
      dwell_cnt_reg <= dwell_cnt_next;
      target_reg    <= target_next;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      servo_pwm_channel #(
        .FRAME_W    (FRAME_W),
        .PULSE_MIN  (PULSE_MIN),
        .PULSE_STEP (PULSE_STEP),
        .SLEW       (SLEW),
        .HOME_ANGLE (HOME_ANGLE)
      ) u_ch (
        .CLK        (CLK),
        .RST        (RST),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt_reg),
        .target     (target_reg[gi]),
        .angle      (angle[gi]),
        .pwm        (PWM[gi])
      );
    end
  endgenerate

  assign rom_addr = rom_addr_reg;
  assign busy     = busy_w;
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_servo_trajectory_player.sv
// Testbench for servo_trajectory_player. Two instances share clock and reset:
// dut_a jumps straight to targets, dut_b is slew limited to 10 degrees/frame.
// Each table row is one PWM frame, started on a frame_tick, with expected
// high-cycle counts per channel and the control outputs at frame end.
module tb_servo_trajectory_player;

  localparam int FC = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, stop_a, loop_a, start_b, stop_b, loop_b;
  logic [7:0]  last_a, last_b, addr_a, addr_b;
  logic [31:0] rom_data_a, rom_data_b;
  logic [2:0]  pwm_a, pwm_b;
  logic        busy_a, done_a, tick_a, busy_b, done_b, tick_b;
  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];

  int checks = 0;
  int errors = 0;
  int hi_a [3];
  int hi_b [3];
  logic seen_done_a;

  typedef struct {
    logic       start_a;
    logic       start_b;
    logic [7:0] last_a;
    logic       loop_a;
    int         wa0, wa1, wa2;
    int         wb0, wb1, wb2;
    logic       busy_a;
    logic       done_a;
    logic [7:0] addr_a;
  } row_t;

  row_t rows [13];
  row_t hand;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data_a <= rom_a[addr_a];
    rom_data_b <= rom_b[addr_b];
  end

  servo_trajectory_player #(
    .N_CH(3), .ADDR_W(8), .DWELL_W(8), .FRAME_CYCLES(FC),
    .PULSE_MIN(50), .PULSE_STEP(2), .SLEW(0), .HOME_ANGLE(90)
  ) dut_a (
    .CLK(clk), .RST(rst), .start(start_a), .stop(stop_a), .loop_en(loop_a),
    .last_addr(last_a), .rom_addr(addr_a), .rom_data(rom_data_a),
    .PWM(pwm_a), .busy(busy_a), .done(done_a), .frame_tick(tick_a)
  );

  servo_trajectory_player #(
    .N_CH(3), .ADDR_W(8), .DWELL_W(8), .FRAME_CYCLES(FC),
    .PULSE_MIN(50), .PULSE_STEP(2), .SLEW(10), .HOME_ANGLE(90)
  ) dut_b (
    .CLK(clk), .RST(rst), .start(start_b), .stop(stop_b), .loop_en(loop_b),
    .last_addr(last_b), .rom_addr(addr_b), .rom_data(rom_data_b),
    .PWM(pwm_b), .busy(busy_b), .done(done_b), .frame_tick(tick_b)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance to the next negedge on which frame_tick is high.
  task automatic wait_tick();
    int found;
    found = 0;
    for (int k = 0; k < 2 * FC + 10; k++) begin
      @(negedge clk);
      if (tick_a) begin
        found = 1;
        break;
      end
    end
    check("wait_tick", found, 1);
  endtask

  // Called on a tick negedge; counts PWM high cycles of the next frame and
  // returns on the following tick negedge.
  task automatic run_frame(input logic sa, input logic sb);
    for (int c = 0; c < 3; c++) begin
      hi_a[c] = 0;
      hi_b[c] = 0;
    end
    seen_done_a = 1'b0;
    start_a = sa;
    start_b = sb;
    for (int k = 0; k < FC; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      for (int c = 0; c < 3; c++) begin
        if (pwm_a[c]) hi_a[c]++;
        if (pwm_b[c]) hi_b[c]++;
      end
      if (done_a) seen_done_a = 1'b1;
    end
  endtask

  task automatic apply_row(input row_t r, input string tag);
    last_a = r.last_a;
    loop_a = r.loop_a;
    run_frame(r.start_a, r.start_b);
    check($sformatf("%s width_a ch0", tag), hi_a[0], r.wa0);
    check($sformatf("%s width_a ch1", tag), hi_a[1], r.wa1);
    check($sformatf("%s width_a ch2", tag), hi_a[2], r.wa2);
    check($sformatf("%s width_b ch0", tag), hi_b[0], r.wb0);
    check($sformatf("%s width_b ch1", tag), hi_b[1], r.wb1);
    check($sformatf("%s width_b ch2", tag), hi_b[2], r.wb2);
    check($sformatf("%s frame_tick", tag), int'(tick_a), 1);
    check($sformatf("%s busy", tag), int'(busy_a), int'(r.busy_a));
    check($sformatf("%s done", tag), int'(done_a), int'(r.done_a));
    check($sformatf("%s rom_addr", tag), int'(addr_a), int'(r.addr_a));
    if (!r.done_a) check($sformatf("%s done_glitch", tag), int'(seen_done_a), 0);
    $display("%s: widths_a %0d/%0d/%0d widths_b %0d/%0d/%0d busy=%0d done=%0d addr=%0d",
             tag, hi_a[0], hi_a[1], hi_a[2], hi_b[0], hi_b[1], hi_b[2], busy_a, done_a, addr_a);
  endtask

  initial begin
    // {start_a, start_b, last_a, loop_a, widths_a x3, widths_b x3, busy, done, addr}
    rows[0]  = '{1'b0, 1'b0, 8'd0, 1'b0,  230, 230, 230,  230, 230, 230, 1'b0, 1'b0, 8'd0};
    rows[1]  = '{1'b1, 1'b1, 8'd0, 1'b0,  230, 230, 230,  230, 230, 230, 1'b1, 1'b0, 8'd0};
    rows[2]  = '{1'b0, 1'b0, 8'd0, 1'b0,   50, 410, 140,  210, 230, 250, 1'b1, 1'b0, 8'd0};
    rows[3]  = '{1'b0, 1'b0, 8'd0, 1'b0,   50, 410, 140,  190, 230, 270, 1'b0, 1'b1, 8'd0};
    rows[4]  = '{1'b0, 1'b0, 8'd0, 1'b0,   50, 410, 140,  170, 230, 290, 1'b0, 1'b1, 8'd0};
    rows[5]  = '{1'b1, 1'b0, 8'd1, 1'b1,   50, 410, 140,  150, 230, 310, 1'b1, 1'b0, 8'd0};
    rows[6]  = '{1'b0, 1'b0, 8'd1, 1'b1,   50, 410, 140,  130, 230, 330, 1'b1, 1'b0, 8'd0};
    rows[7]  = '{1'b0, 1'b0, 8'd1, 1'b1,   50, 410, 140,  110, 230, 350, 1'b1, 1'b0, 8'd1};
    rows[8]  = '{1'b0, 1'b0, 8'd1, 1'b1,  130, 150, 170,   90, 230, 370, 1'b1, 1'b0, 8'd0};
    rows[9]  = '{1'b0, 1'b0, 8'd1, 1'b1,   50, 410, 140,   70, 230, 390, 1'b1, 1'b0, 8'd0};
    rows[10] = '{1'b0, 1'b0, 8'd1, 1'b1,   50, 410, 140,   50, 230, 410, 1'b1, 1'b0, 8'd1};
    rows[11] = '{1'b0, 1'b0, 8'd1, 1'b1,  130, 150, 170,   50, 230, 410, 1'b1, 1'b0, 8'd0};
    rows[12] = '{1'b0, 1'b0, 8'd1, 1'b1,   50, 410, 140,   50, 230, 410, 1'b1, 1'b0, 8'd0};

    rom_a[0] = {8'd0,  8'd180, 8'd45, 8'd2};
    rom_a[1] = {8'd40, 8'd50,  8'd60, 8'd1};
    rom_b[0] = {8'd0,  8'd90,  8'd180, 8'd20};

    rst = 1'b1;
    start_a = 1'b0; stop_a = 1'b0; loop_a = 1'b0; last_a = 8'd0;
    start_b = 1'b0; stop_b = 1'b0; loop_b = 1'b0; last_b = 8'd0;

    repeat (3) @(negedge clk);
    check("reset pwm_a", int'(pwm_a), 0);
    check("reset pwm_b", int'(pwm_b), 0);
    check("reset busy", int'(busy_a), 0);
    check("reset done", int'(done_a), 0);
    check("reset frame_tick", int'(tick_a), 0);
    check("reset rom_addr", int'(addr_a), 0);
    $display("reset: pwm_a=%0d busy=%0d done=%0d addr=%0d", pwm_a, busy_a, done_a, addr_a);
    rst = 1'b0;

    wait_tick();
    for (int r = 0; r < 13; r++) begin
      apply_row(rows[r], $sformatf("row%0d", r));
    end

    // Stop mid-HOLD while step 1 targets are latched but not yet applied.
    repeat (100) @(negedge clk);
    check("pre_stop busy", int'(busy_a), 1);
    check("pre_stop rom_addr", int'(addr_a), 1);
    stop_a = 1'b1;
    @(negedge clk);
    stop_a = 1'b0;
    check("stop busy", int'(busy_a), 0);
    check("stop done", int'(done_a), 0);
    $display("stop: busy=%0d done=%0d", busy_a, done_a);
    wait_tick();
    hand = '{1'b0, 1'b0, 8'd1, 1'b1, 50, 410, 140, 50, 230, 410, 1'b0, 1'b0, 8'd1};
    apply_row(hand, "frozen");

    // start and stop together from IDLE: stop wins.
    start_a = 1'b1;
    stop_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    stop_a  = 1'b0;
    check("start_stop busy", int'(busy_a), 0);
    $display("start+stop: busy=%0d", busy_a);

    // Out-of-range angles clamp to 180; dwell 0 behaves as 1.
    rom_a[0] = {8'd200, 8'd255, 8'd100, 8'd0};
    wait_tick();
    hand = '{1'b1, 1'b0, 8'd0, 1'b0, 50, 410, 140, 50, 230, 410, 1'b1, 1'b0, 8'd0};
    apply_row(hand, "clamp0");
    hand = '{1'b0, 1'b0, 8'd0, 1'b0, 410, 410, 250, 50, 230, 410, 1'b0, 1'b1, 8'd0};
    apply_row(hand, "clamp1");

    // Reset in the middle of a pulse.
    repeat (100) @(negedge clk);
    check("pre_reset pwm_a", int'(pwm_a), 7);
    #2 rst = 1'b1;
    #1;
    check("async_reset pwm_a", int'(pwm_a), 0);
    check("async_reset pwm_b", int'(pwm_b), 0);
    check("async_reset done", int'(done_a), 0);
    check("async_reset rom_addr", int'(addr_a), 0);
    $display("async reset: pwm_a=%0d pwm_b=%0d done=%0d", pwm_a, pwm_b, done_a);
    @(negedge clk);
    rst = 1'b0;
    wait_tick();
    hand = '{1'b0, 1'b0, 8'd0, 1'b0, 230, 230, 230, 230, 230, 230, 1'b0, 1'b0, 8'd0};
    apply_row(hand, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
